display_source_mux: RTL and testbench
=====================================

DISPLAY_SOURCE_MUX -- requirements
Module: display_source_mux

Interface
REQ-001 Parameter NUM_SOURCES, default 2: number of time sources (2..8).
REQ-002 Parameter DECIMAL_DIGITS, default 4: BCD digits per source, 4 bits each.
REQ-003 Parameter DWELL_CYCLES, default 100_000_000: auto-rotate dwell per source, in clocks (>=2).
REQ-004 Parameter BLINK_HALF_CYCLES, default 50_000_000: blink half-period, in clocks (>=2).
REQ-005 Derived SEL_W = clog2(max(NUM_SOURCES,2)); DW = DECIMAL_DIGITS*4.
REQ-006 i_Clk  in  1  system clock; all state on rising edge.
REQ-007 i_Rst_n  in  1  reset, asynchronous, active-low.
REQ-008 i_Mode  in  1  0 = manual select, 1 = auto-rotate.
REQ-009 i_Sel  in  SEL_W  manual source index.
REQ-010 i_Time  in  NUM_SOURCES*DW  packed BCD times; source k at bits [k*DW +: DW].
REQ-011 i_PM  in  NUM_SOURCES  PM flag per source.
REQ-012 i_Blink  in  1  request blinking of displayed value.
REQ-013 o_Display_Time  out  DW  selected source time, registered.
REQ-014 o_Display_PM  out  1  selected source PM flag, registered.
REQ-015 o_Display_Blank  out  1  1 = display dark (blink off-phase).
REQ-016 o_Active_Sel  out  SEL_W  index of source currently shown.

Function
REQ-017 State machine MANUAL/AUTO SHALL follow i_Mode registered: MANUAL->AUTO when i_Mode=1, AUTO->MANUAL when i_Mode=0.
REQ-018 MANUAL: active index SHALL load i_Sel each cycle; i_Sel >= NUM_SOURCES SHALL hold the previous active index.
REQ-019 AUTO: dwell counter counts 0..DWELL_CYCLES-1; at terminal count active index SHALL increment, wrapping NUM_SOURCES-1 -> 0, counter returns to 0.
REQ-020 Entry to AUTO SHALL keep current active index and clear dwell counter; first advance occurs DWELL_CYCLES clocks after entry.
REQ-021 Mode change coinciding with dwell terminal: mode change wins, no advance.
REQ-022 Dwell counter SHALL be held at 0 in MANUAL.
REQ-023 o_Display_Time/o_Display_PM SHALL equal the active source slice with one-clock latency from active index or input data change (live data, not latched at switch).
REQ-024 o_Active_Sel SHALL update in the same cycle as o_Display_Time for a given switch.

Reset
REQ-025 While i_Rst_n=0: state MANUAL, active index 0, dwell and blink counters 0, all outputs 0, asynchronously.
REQ-026 Reset deassertion mid-rotation SHALL restart from index 0 in MANUAL; no partial dwell retained.

Configuration
REQ-027 Macro DISPLAY_MUX_BLINK_EN defined: blink counter counts 0..BLINK_HALF_CYCLES-1 while i_Blink=1, o_Display_Blank toggles at each terminal count starting from 0.
REQ-028 With macro, i_Blink=0 SHALL clear blink counter and force o_Display_Blank=0 next clock.
REQ-029 Macro undefined: o_Display_Blank tied 0, i_Blink ignored, blink counter not instantiated; port list unchanged.

Structure
REQ-030 Package display_mux_pkg SHALL hold the MANUAL/AUTO state type and the SEL_W width function.
REQ-031 Sub-module display_tick_counter (parametrised terminal count, enable, synchronous clear, terminal pulse) SHALL implement both dwell and blink counters.

Verification (NUM_SOURCES=3, DECIMAL_DIGITS=4, DWELL_CYCLES=4, BLINK_HALF_CYCLES=3)
REQ-032 Reset then i_Sel=2, i_Time={16'h0953,16'h0516,16'h1228}, i_PM=3'b100 -> one clock later o_Display_Time=16'h0953, o_Display_PM=1, o_Active_Sel=2.
REQ-033 MANUAL, active=1, i_Sel=3 -> o_Active_Sel stays 1, o_Display_Time=16'h0516.
REQ-034 i_Mode=1 from active=1 -> active 1,2,0,1 changing every 4 clocks; wrap 2->0 observed.
REQ-035 AUTO with i_Mode=0 on dwell terminal cycle, i_Sel=0 -> no advance, active=0 next cycle.
REQ-036 Macro on, i_Blink=1 for 12 clocks -> o_Display_Blank pattern 0,1,0,1 each lasting 3 clocks; i_Blink=0 -> 0 next clock; macro off -> always 0.
REQ-037 i_Rst_n pulsed low mid-dwell in AUTO -> outputs 0 immediately; after release, MANUAL, index 0.

Source files
------------

// File: rtl/display_mux_pkg.sv
// Shared types and helpers for the display source multiplexer.
package display_mux_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mux_state_e;

  // Select width never drops below one bit, even for a single source.
  function automatic int sel_width(input int num_sources);
    return (num_sources < 2) ? 1 : $clog2(num_sources);
  endfunction

endpackage

// File: rtl/display_tick_counter.sv
// Modulo-TERMINAL tick counter with enable and synchronous clear.
// Emits a one-cycle terminal pulse when the last count is reached while enabled.
module display_tick_counter #(
  parameter int TERMINAL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tick = en && !clr && (count_q == CNT_W'(TERMINAL - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/display_source_mux.sv
// Selects one of several BCD time sources for display, manually or by auto-rotation.
// Optional blinking is enabled by defining DISPLAY_MUX_BLINK_EN.
module display_source_mux
  import display_mux_pkg::*;
#(
  parameter int NUM_SOURCES       = 2,
  parameter int DECIMAL_DIGITS    = 4,
  parameter int DWELL_CYCLES      = 100_000_000,
  parameter int BLINK_HALF_CYCLES = 50_000_000,
  localparam int SEL_W            = sel_width(NUM_SOURCES),
  localparam int DW               = DECIMAL_DIGITS * 4
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_n,
  input  logic                      i_Mode,
  input  logic [SEL_W-1:0]          i_Sel,
  input  logic [NUM_SOURCES*DW-1:0] i_Time,
  input  logic [NUM_SOURCES-1:0]    i_PM,
  input  logic                      i_Blink,
  output logic [DW-1:0]             o_Display_Time,
  output logic                      o_Display_PM,
  output logic                      o_Display_Blank,
  output logic [SEL_W-1:0]          o_Active_Sel
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SOURCES - 1);

  mux_state_e       state_q;
  mux_state_e       state_d;
  logic [SEL_W-1:0] active_q;
  logic [SEL_W-1:0] active_d;
  logic [DW-1:0]    time_q;
  logic [DW-1:0]    time_d;
  logic             pm_q;
  logic             pm_d;

  logic sel_valid;
  logic dwell_en;
  logic dwell_tick;

  assign sel_valid = ({{(32 - SEL_W){1'b0}}, i_Sel} < 32'(NUM_SOURCES));

  // Dwell only runs once already in AUTO; entry and exit cycles keep it cleared.
  assign dwell_en = (state_q == AUTO) && i_Mode;

  display_tick_counter #(
    .TERMINAL (DWELL_CYCLES)
  ) u_dwell_cnt (
    .clk   (i_Clk),
    .rst_n (i_Rst_n),
    .en    (dwell_en),
    .clr   (!dwell_en),
    .tick  (dwell_tick)
  );

  always_comb begin
    state_d  = i_Mode ? AUTO : MANUAL;
    active_d = active_q;
    if (!i_Mode) begin
      if (sel_valid) begin
        active_d = i_Sel;
      end
    end else if (dwell_tick) begin
      active_d = (active_q == LAST_IDX) ? '0 : active_q + SEL_W'(1);
    end
  end

  // Output data follows the next active index so it lands alongside o_Active_Sel.
  always_comb begin
    time_d = '0;
    pm_d   = 1'b0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (active_d == SEL_W'(k)) begin
        time_d = i_Time[k*DW +: DW];
        pm_d   = i_PM[k];
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= MANUAL;
      active_q <= '0;
      time_q   <= '0;
      pm_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      time_q   <= time_d;
      pm_q     <= pm_d;
    end
  end

  assign o_Display_Time = time_q;
  assign o_Display_PM   = pm_q;
  assign o_Active_Sel   = active_q;

`ifdef DISPLAY_MUX_BLINK_EN
  logic blink_tick;
  logic blank_q;
  logic blank_d;

  display_tick_counter #(
    .TERMINAL (BLINK_HALF_CYCLES)
  ) u_blink_cnt (
    .clk   (i_Clk),
    .rst_n (i_Rst_n),
    .en    (i_Blink),
    .clr   (!i_Blink),
    .tick  (blink_tick)
  );

  always_comb begin
    blank_d = 1'b0;
    if (i_Blink) begin
      blank_d = blank_q ^ blink_tick;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign o_Display_Blank = blank_q;
`else
  logic unused_blink;
  assign unused_blink    = i_Blink;
  assign o_Display_Blank = 1'b0;
`endif

endmodule

// File: tb/tb_display_source_mux.sv
// Self-checking bench for display_source_mux: vector table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_display_source_mux;

  localparam int N     = 3;
  localparam int DW    = 16;
  localparam int DWELL = 4;
  localparam int BH    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode;
  logic [1:0]    sel;
  logic [47:0]   time_in;
  logic [2:0]    pm;
  logic          blink;
  logic [15:0]   disp_time;
  logic          disp_pm;
  logic          disp_blank;
  logic [1:0]    active_sel;

  int checks   = 0;
  int failures = 0;

  bit          m_auto;
  int          m_active;
  int          m_dwell;
  int          m_blink;
  bit          m_blank;
  logic [15:0] req_time;
  logic        req_pm;
  logic        req_blank;
  logic [1:0]  req_sel;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [47:0] t;
    logic [2:0]  pm;
    logic [15:0] e_time;
    logic        e_pm;
    logic [1:0]  e_sel;
  } vec_t;

  vec_t vecs[7];
  int   exp_rot[13];
  logic blink_pat[12];

  display_source_mux #(
    .NUM_SOURCES       (N),
    .DECIMAL_DIGITS    (4),
    .DWELL_CYCLES      (DWELL),
    .BLINK_HALF_CYCLES (BH)
  ) dut (
    .i_Clk           (clk),
    .i_Rst_n         (rst_n),
    .i_Mode          (mode),
    .i_Sel           (sel),
    .i_Time          (time_in),
    .i_PM            (pm),
    .i_Blink         (blink),
    .o_Display_Time  (disp_time),
    .o_Display_PM    (disp_pm),
    .o_Display_Blank (disp_blank),
    .o_Active_Sel    (active_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    m_auto    = 1'b0;
    m_active  = 0;
    m_dwell   = 0;
    m_blink   = 0;
    m_blank   = 1'b0;
    req_time  = '0;
    req_pm    = 1'b0;
    req_blank = 1'b0;
    req_sel   = '0;
  endtask

  // One clock of the rules: mode follows i_Mode, manual loads valid selects,
  // auto advances after a full dwell, blink toggles every half period.
  task automatic modelStep();
    if (!mode) begin
      m_auto  = 1'b0;
      m_dwell = 0;
      if (int'(sel) < N) m_active = int'(sel);
    end else if (!m_auto) begin
      m_auto  = 1'b1;
      m_dwell = 0;
    end else if (m_dwell == DWELL - 1) begin
      m_dwell  = 0;
      m_active = (m_active + 1) % N;
    end else begin
      m_dwell++;
    end
    if (!blink) begin
      m_blink = 0;
      m_blank = 1'b0;
    end else if (m_blink == BH - 1) begin
      m_blink = 0;
      m_blank = !m_blank;
    end else begin
      m_blink++;
    end
    req_time = time_in[m_active*DW +: DW];
    req_pm   = pm[m_active];
    req_sel  = 2'(m_active);
`ifdef DISPLAY_MUX_BLINK_EN
    req_blank = m_blank;
`else
    req_blank = 1'b0;
`endif
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_time"},  32'(disp_time),  32'(req_time));
    checkVal({tag, "_pm"},    32'(disp_pm),    32'(req_pm));
    checkVal({tag, "_blank"}, 32'(disp_blank), 32'(req_blank));
    checkVal({tag, "_sel"},   32'(active_sel), 32'(req_sel));
  endtask

  task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [47:0] t,
                               input logic [2:0] p, input logic b);
    mode    = m;
    sel     = s;
    time_in = t;
    pm      = p;
    blink   = b;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  localparam logic [47:0] T0 = {16'h0953, 16'h0516, 16'h1228};
  localparam logic [47:0] T1 = {16'h1111, 16'h2222, 16'h3333};
  localparam logic [47:0] T2 = {16'h4444, 16'h5555, 16'h6666};

  initial begin
    vecs[0] = '{1'b0, 2'd2, T0, 3'b100, 16'h0953, 1'b1, 2'd2};
    vecs[1] = '{1'b0, 2'd1, T0, 3'b100, 16'h0516, 1'b0, 2'd1};
    vecs[2] = '{1'b0, 2'd3, T0, 3'b100, 16'h0516, 1'b0, 2'd1};
    vecs[3] = '{1'b0, 2'd0, T0, 3'b100, 16'h1228, 1'b0, 2'd0};
    vecs[4] = '{1'b0, 2'd0, T1, 3'b001, 16'h3333, 1'b1, 2'd0};
    vecs[5] = '{1'b0, 2'd3, T2, 3'b011, 16'h6666, 1'b1, 2'd0};
    vecs[6] = '{1'b0, 2'd2, T2, 3'b011, 16'h4444, 1'b0, 2'd2};
    exp_rot   = '{1, 1, 1, 1, 2, 2, 2, 2, 0, 0, 0, 0, 1};
    blink_pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, '0, '0, 1'b0);
    modelReset();
    #12;
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].mode, vecs[i].sel, vecs[i].t, vecs[i].pm, 1'b0);
      cycle("vec");
      checkVal("vec_tbl_time", 32'(disp_time),  32'(vecs[i].e_time));
      checkVal("vec_tbl_pm",   32'(disp_pm),    32'(vecs[i].e_pm));
      checkVal("vec_tbl_sel",  32'(active_sel), 32'(vecs[i].e_sel));
    end

    // Rotation from index 1 including the 2 -> 0 wrap.
    applyStimulus(1'b0, 2'd1, T0, 3'b100, 1'b0);
    cycle("pre_rot");
    mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cycle("rot");
      checkVal("rot_sel", 32'(active_sel), 32'(exp_rot[i]));
    end

    // Leave AUTO exactly on the dwell terminal cycle.
    for (int i = 0; i < 3; i++) cycle("pre_exit");
    applyStimulus(1'b0, 2'd0, T0, 3'b100, 1'b0);
    cycle("exit");
    checkVal("exit_sel", 32'(active_sel), 32'd0);
    checkVal("exit_time", 32'(disp_time), 32'h1228);

    applyStimulus(1'b0, 2'd2, T0, 3'b100, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycle("blink");
`ifdef DISPLAY_MUX_BLINK_EN
      checkVal("blink_pat", 32'(disp_blank), 32'(blink_pat[i]));
`else
      checkVal("blank_tied", 32'(disp_blank), 32'd0);
`endif
    end
    blink = 1'b0;
    cycle("blink_off");
    checkVal("blink_off_blank", 32'(disp_blank), 32'd0);

    // Asynchronous reset in the middle of a dwell.
    applyStimulus(1'b1, 2'd0, T0, 3'b100, 1'b0);
    cycle("auto_entry");
    cycle("auto_mid");
    cycle("auto_mid");
    checkVal("pre_rst_sel", 32'(active_sel), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst");
    checkVal("post_rst_sel", 32'(active_sel), 32'd0);
    for (int i = 0; i < 5; i++) cycle("post_rst_auto");
    applyStimulus(1'b0, 2'd3, T1, 3'b010, 1'b0);
    cycle("post_rst_hold");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) mode = !mode;
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) time_in = 48'({$urandom(), $urandom()});
      pm = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) blink = !blink;
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
